// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: 2-entry skid buffer with valid/ready handshake, stall and flush.
// Optional saturating stall counter enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 145,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_m;
  logic [DATA_W-1:0] r_s;

  logic w_accept;
  logic w_pop;

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = r_out_valid & out_ready;

  // M is always the older entry; emptied registers are zeroed so invalid cycles present NOP.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state     <= ST_EMPTY;
      r_m         <= '0;
      r_s         <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_ONE;
            r_m         <= in_data;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            r_m <= in_data;
          end else if (w_accept) begin
            r_state    <= ST_FULL;
            r_s        <= in_data;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            r_state     <= ST_EMPTY;
            r_m         <= '0;
            r_out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_state    <= ST_ONE;
            r_m        <= r_s;
            r_s        <= '0;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_m         <= '0;
          r_s         <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_m;

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles where a valid item is held back; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
